// File: rtl/obstacle_spawner.sv
// obstacle_spawner: scrolling obstacle slot pool fed by the 2-bit random stream.
// Optional NO_DOUBLE_BIRD_EN forbids two consecutive bird (11) spawns.
package obstacle_spawner_pkg;
  typedef enum logic [1:0] {IDLE, RUN, OVER, WIN} state_t;
endpackage

module obstacle_spawner import obstacle_spawner_pkg::*; #(
  parameter int NSLOT = 4,
  parameter int XW = 8,
  parameter int SPAWN_X = 159,
  parameter int SPEED = 2,
  parameter int MIN_GAP = 24,
  parameter int GAP_STEP = 8,
  parameter int FIRST_GAP = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  state_t             state,
  input  logic [1:0]         rnd,
  input  logic               scroll_tick,
  output logic [NSLOT-1:0]   slot_valid,
  output logic [NSLOT*XW-1:0] slot_x,
  output logic [NSLOT*2-1:0] slot_type,
  output logic               spawn_pulse,
  output logic [7:0]         passed_cnt
);
  logic [7:0] gap_cnt, gap_n, retired, passed_n;
  logic [8:0] pass_sum;
  logic [NSLOT-1:0] valid_n;
  logic [NSLOT*XW-1:0] x_n;
  logic [NSLOT*2-1:0] type_n;
  logic spawn_n, placed;
  logic [1:0] new_type;
`ifdef NO_DOUBLE_BIRD_EN
  logic last_bird, last_bird_n;
`endif
  always_comb begin
    valid_n = slot_valid;
    x_n = slot_x;
    type_n = slot_type;
    passed_n = passed_cnt;
    gap_n = gap_cnt;
    spawn_n = 1'b0;
    retired = '0;
    placed = 1'b0;
    pass_sum = '0;
`ifdef NO_DOUBLE_BIRD_EN
    new_type = (last_bird && rnd == 2'b11) ? 2'b00 : rnd;
    last_bird_n = last_bird;
`else
    new_type = rnd;
`endif
    if (state == IDLE) begin
      valid_n = '0;
      x_n = '0;
      type_n = '0;
      passed_n = '0;
      gap_n = 8'(FIRST_GAP);
`ifdef NO_DOUBLE_BIRD_EN
      last_bird_n = 1'b0;
`endif
    end else if (state == RUN && scroll_tick) begin
      for (int i = 0; i < NSLOT; i++)
        if (slot_valid[i]) begin
          if (slot_x[i*XW +: XW] >= XW'(SPEED)) x_n[i*XW +: XW] = slot_x[i*XW +: XW] - XW'(SPEED);
          else begin
            valid_n[i] = 1'b0;
            x_n[i*XW +: XW] = '0;
            type_n[i*2 +: 2] = '0;
            retired = retired + 8'd1;
          end
        end
      pass_sum = {1'b0, passed_cnt} + {1'b0, retired};
      passed_n = pass_sum[8] ? 8'hFF : pass_sum[7:0];
      // Only slots free before this tick may take the spawn; a just-retired slot waits a tick.
      if (gap_cnt != 8'd0) gap_n = gap_cnt - 8'd1;
      else
        for (int i = 0; i < NSLOT; i++)
          if (!slot_valid[i] && !placed) begin
            placed = 1'b1;
            valid_n[i] = 1'b1;
            x_n[i*XW +: XW] = XW'(SPAWN_X);
            type_n[i*2 +: 2] = new_type;
            spawn_n = 1'b1;
            gap_n = 8'(MIN_GAP + GAP_STEP * int'(rnd));
`ifdef NO_DOUBLE_BIRD_EN
            last_bird_n = (new_type == 2'b11);
`endif
          end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= '0;
      slot_x <= '0;
      slot_type <= '0;
      spawn_pulse <= 1'b0;
      passed_cnt <= '0;
      gap_cnt <= 8'(FIRST_GAP);
`ifdef NO_DOUBLE_BIRD_EN
      last_bird <= 1'b0;
`endif
    end else begin
      slot_valid <= valid_n;
      slot_x <= x_n;
      slot_type <= type_n;
      spawn_pulse <= spawn_n;
      passed_cnt <= passed_n;
      gap_cnt <= gap_n;
`ifdef NO_DOUBLE_BIRD_EN
      last_bird <= last_bird_n;
`endif
    end
  end
endmodule

// File: tb/tb_obstacle_spawner.sv
// tb_obstacle_spawner: random and directed checks of obstacle_spawner (4-slot and 2-slot builds)
module tb_obstacle_spawner;
  import obstacle_spawner_pkg::*;
  logic clk = 1'b0;
  logic reset, scroll_tick;
  state_t state;
  logic [1:0] rnd;
  logic [3:0] v4;
  logic [31:0] x4;
  logic [7:0] t4, c4, c2;
  logic p4, p2;
  logic [1:0] v2;
  logic [15:0] x2;
  logic [3:0] t2;
  logic [60:0] sig0, sig1;
  int checks = 0, errors = 0;
`ifdef NO_DOUBLE_BIRD_EN
  localparam bit NDB = 1'b1;
`else
  localparam bit NDB = 1'b0;
`endif

  always #5 clk = ~clk;

  obstacle_spawner dut (.clk(clk), .reset(reset), .state(state), .rnd(rnd), .scroll_tick(scroll_tick),
    .slot_valid(v4), .slot_x(x4), .slot_type(t4), .spawn_pulse(p4), .passed_cnt(c4));
  obstacle_spawner #(.NSLOT(2)) dut2 (.clk(clk), .reset(reset), .state(state), .rnd(rnd), .scroll_tick(scroll_tick),
    .slot_valid(v2), .slot_x(x2), .slot_type(t2), .spawn_pulse(p2), .passed_cnt(c2));

  assign sig0 = {dut.gap_cnt, v4, x4, t4, p4, c4};
  assign sig1 = {dut2.gap_cnt, 2'b0, v2, 16'b0, x2, 4'b0, t2, p2, c2};

  // Reference model: obstacles as (valid, x, type) entries, one pool per instance.
  bit m_v[2][4];
  int m_x[2][4];
  logic [1:0] m_t[2][4];
  int m_pass[2], m_gap[2], m_last[2];
  bit m_pulse[2], m_lb[2];

  function automatic int ns(int k);
    return k == 0 ? 4 : 2;
  endfunction

  task automatic model_update(int k, logic rs, state_t st, logic tk, logic [1:0] r);
    int fr, ret;
    m_pulse[k] = 1'b0;
    if (rs || st == IDLE) begin
      for (int i = 0; i < 4; i++) begin m_v[k][i] = 0; m_x[k][i] = 0; m_t[k][i] = 0; end
      m_gap[k] = 40;
      m_lb[k] = 0;
      m_pass[k] = 0;
    end else if (st == RUN && tk) begin
      fr = -1;
      for (int i = 0; i < ns(k); i++) if (!m_v[k][i] && fr < 0) fr = i;
      ret = 0;
      for (int i = 0; i < ns(k); i++)
        if (m_v[k][i]) begin
          if (m_x[k][i] >= 2) m_x[k][i] -= 2;
          else begin m_v[k][i] = 0; m_x[k][i] = 0; m_t[k][i] = 0; ret++; end
        end
      m_pass[k] = (m_pass[k] + ret > 255) ? 255 : m_pass[k] + ret;
      if (m_gap[k] > 0) m_gap[k]--;
      else if (fr >= 0) begin
        m_v[k][fr] = 1;
        m_x[k][fr] = 159;
        m_t[k][fr] = (NDB && m_lb[k] && r == 2'd3) ? 2'd0 : r;
        m_lb[k] = (m_t[k][fr] == 2'd3);
        m_pulse[k] = 1'b1;
        m_gap[k] = 24 + 8 * int'(r);
        m_last[k] = fr;
      end
    end
  endtask

  function automatic logic [60:0] exp_sig(int k);
    logic [3:0] v;
    logic [31:0] x;
    logic [7:0] t;
    v = '0; x = '0; t = '0;
    for (int i = 0; i < ns(k); i++) begin
      v[i] = m_v[k][i];
      x[i*8 +: 8] = 8'(m_x[k][i]);
      t[i*2 +: 2] = m_t[k][i];
    end
    return {8'(m_gap[k]), v, x, t, m_pulse[k], 8'(m_pass[k])};
  endfunction

  task automatic step(input logic rs, input state_t st, input logic tk, input logic [1:0] r);
    reset = rs; state = st; scroll_tick = tk; rnd = r;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k, rs, st, tk, r);
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int c = 0; c < 2; c++) step(1'b1, RUN, 1'b1, 2'd3);
    checks++;
    if (sig0 !== {8'd40, 53'd0} || sig1 !== {8'd40, 53'd0}) begin
      errors++; $display("FAIL reset: dut4=%h dut2=%h want gap 40 and zeros", sig0, sig1);
    end
    step(1'b0, IDLE, 1'b0, 2'd0);
    checks++;
    if (sig0 !== exp_sig(0) || sig1 !== exp_sig(1)) begin
      errors++; $display("FAIL idle_after_reset: dut4=%h exp4=%h dut2=%h exp2=%h", sig0, exp_sig(0), sig1, exp_sig(1));
    end
  endtask

  task automatic test_first_spawn;
    int first = 0;
    step(1'b0, IDLE, 1'b0, 2'd0);
    for (int t = 1; t <= 90; t++) begin
      step(1'b0, RUN, 1'b1, 2'd2);
      if (p4 && first == 0) first = t;
      checks++;
      if (sig0 !== exp_sig(0) || sig1 !== exp_sig(1)) begin
        errors++; $display("FAIL first_spawn t=%0d: dut4=%h exp4=%h dut2=%h exp2=%h", t, sig0, exp_sig(0), sig1, exp_sig(1));
      end
      if (t == 41) begin
        checks++;
        if ({v4[0], x4[7:0], t4[1:0]} !== {1'b1, 8'd159, 2'b10}) begin
          errors++; $display("FAIL spawn_slot0: got v=%b x=%0d t=%b want 1/159/10", v4[0], x4[7:0], t4[1:0]);
        end
      end
      if (t == 42) begin
        checks++;
        if (x4[7:0] !== 8'd157) begin errors++; $display("FAIL move_one: x=%0d want 157", x4[7:0]); end
      end
      if (t == 82) begin
        checks++;
        if (!(p4 === 1'b1 && v4[1] === 1'b1)) begin errors++; $display("FAIL second_spawn: pulse=%b v=%b want pulse at tick 82", p4, v4); end
      end
    end
    checks++;
    if (first != 41) begin errors++; $display("FAIL first_spawn_tick: got %0d want 41", first); end
  endtask

  task automatic test_fixed_gap;
    step(1'b0, IDLE, 1'b0, 2'd0);
    for (int t = 1; t <= 200; t++) begin
      step(1'b0, RUN, 1'b1, 2'd0);
      checks++;
      if (sig0 !== exp_sig(0) || sig1 !== exp_sig(1)) begin
        errors++; $display("FAIL fixed_gap t=%0d: dut4=%h exp4=%h dut2=%h exp2=%h", t, sig0, exp_sig(0), sig1, exp_sig(1));
      end
      if (t == 121) begin
        checks++;
        if (c4 !== 8'd1 || v4[0] !== 1'b0 || c2 !== 8'd1 || v2 !== 2'b10) begin
          errors++; $display("FAIL retire_tick121: pass4=%0d v4=%b pass2=%0d v2=%b want 1/0 1/10", c4, v4, c2, v2);
        end
      end
      if (t == 122) begin
        checks++;
        if (p2 !== 1'b1 || v2 !== 2'b11 || x2[7:0] !== 8'd159) begin
          errors++; $display("FAIL respawn_slot0: pulse=%b v=%b x=%0d want 1/11/159", p2, v2, x2[7:0]);
        end
      end
    end
  endtask

  task automatic test_freeze_and_clear;
    for (int t = 0; t < 20; t++) begin
      step(1'b0, (t < 10) ? OVER : WIN, 1'b1, 2'($urandom_range(0, 3)));
      checks++;
      if (sig0 !== exp_sig(0) || sig1 !== exp_sig(1)) begin
        errors++; $display("FAIL freeze t=%0d: dut4=%h exp4=%h dut2=%h exp2=%h", t, sig0, exp_sig(0), sig1, exp_sig(1));
      end
    end
    step(1'b0, IDLE, 1'b1, 2'd1);
    checks++;
    if (sig0 !== {8'd40, 53'd0} || sig1 !== {8'd40, 53'd0}) begin
      errors++; $display("FAIL idle_clear: dut4=%h dut2=%h want gap 40 and zeros", sig0, sig1);
    end
    for (int t = 0; t < 60; t++) step(1'b0, RUN, 1'b1, 2'd1);
    step(1'b1, RUN, 1'b1, 2'd1);
    checks++;
    if (sig0 !== {8'd40, 53'd0} || sig1 !== {8'd40, 53'd0}) begin
      errors++; $display("FAIL reset_mid_run: dut4=%h dut2=%h want gap 40 and zeros", sig0, sig1);
    end
  endtask

  task automatic test_random;
    logic rs, tk;
    state_t st;
    step(1'b0, IDLE, 1'b0, 2'd0);
    for (int c = 0; c < 4000; c++) begin
      rs = ($urandom_range(0, 499) == 0);
      st = ($urandom_range(0, 9) < 8) ? RUN : state_t'($urandom_range(0, 3));
      tk = ($urandom_range(0, 3) != 0);
      step(rs, st, tk, 2'($urandom_range(0, 3)));
      checks++;
      if (sig0 !== exp_sig(0) || sig1 !== exp_sig(1)) begin
        errors++; $display("FAIL random c=%0d: dut4=%h exp4=%h dut2=%h exp2=%h", c, sig0, exp_sig(0), sig1, exp_sig(1));
      end
    end
  endtask

  task automatic test_saturate;
    step(1'b0, IDLE, 1'b0, 2'd0);
    for (int t = 1; t <= 7000; t++) begin
      step(1'b0, RUN, 1'b1, 2'd0);
      checks++;
      if (sig0 !== exp_sig(0) || sig1 !== exp_sig(1)) begin
        errors++; $display("FAIL saturate t=%0d: dut4=%h exp4=%h dut2=%h exp2=%h", t, sig0, exp_sig(0), sig1, exp_sig(1));
      end
    end
    checks++;
    if (c4 !== 8'd255) begin errors++; $display("FAIL passed_saturation: got %0d want 255", c4); end
  endtask

`ifdef NO_DOUBLE_BIRD_EN
  task automatic test_no_double_bird;
    logic [1:0] got[4];
    logic [1:0] want[4] = '{2'd3, 2'd0, 2'd3, 2'd0};
    int n = 0;
    step(1'b0, IDLE, 1'b0, 2'd0);
    for (int t = 0; t < 400 && n < 4; t++) begin
      step(1'b0, RUN, 1'b1, 2'd3);
      if (p4) begin got[n] = t4[m_last[0]*2 +: 2]; n++; end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL bird_spawns: got %0d spawns want 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== want[i]) begin errors++; $display("FAIL bird_type%0d: got %b want %b", i, got[i], want[i]); end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; state = IDLE; scroll_tick = 1'b0; rnd = 2'd0;
    for (int k = 0; k < 2; k++) model_update(k, 1'b1, IDLE, 1'b0, 2'd0);
    @(negedge clk);
    test_reset;
    test_first_spawn;
    test_fixed_gap;
    test_freeze_and_clear;
    test_random;
    test_saturate;
`ifdef NO_DOUBLE_BIRD_EN
    test_no_double_bird;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
